// File: rtl/aes_ctrl_pkg.sv
// rtl/aes_ctrl_pkg.sv - shared widths, defaults and state encoding for the AES request arbiter
package aes_ctrl_pkg;

    localparam int AES_W       = 128;
    localparam int NREQ        = 2;
    localparam int DEF_TIMEOUT = 31;
    localparam int DEF_BLANK   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational 2-way round-robin pick
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_valid,
    output logic       o_grant
);

    assign o_valid = |i_req;

    // On a tie, favour whichever requester was not served last.
    always_comb begin
        o_grant = i_req[1];
        if (i_req == 2'b11) begin
            o_grant = ~i_last;
        end
    end

endmodule

// File: rtl/aes_arbiter.sv
// rtl/aes_arbiter.sv - shares one AES core between two requesters with done blanking and timeout
module aes_arbiter
    import aes_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int BLANK   = DEF_BLANK
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*AES_W-1:0]   req_pt,
    input  logic [NREQ*AES_W-1:0]   req_key,
    output logic [NREQ-1:0]         rsp_valid,
    input  logic [NREQ-1:0]         rsp_ready,
    output logic [AES_W-1:0]        rsp_ct,
    output logic                    rsp_err,
    output logic                    aes_start,
    output logic [AES_W-1:0]        aes_pt,
    output logic [AES_W-1:0]        aes_key,
    input  logic [AES_W-1:0]        aes_ct,
    input  logic                    aes_done,
    output logic                    busy
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
    localparam logic [7:0] BLANK_C   = 8'(BLANK);

    state_t             r_state;
    logic               r_gnt;
    logic               r_last;
    logic [7:0]         r_cnt;
    logic [NREQ-1:0]    r_req_ready;
    logic [NREQ-1:0]    r_rsp_valid;
    logic [AES_W-1:0]   r_rsp_ct;
    logic               r_rsp_err;
    logic               r_aes_start;
    logic [AES_W-1:0]   r_aes_pt;
    logic [AES_W-1:0]   r_aes_key;

    logic               w_any;
    logic               w_gnt;
    logic               w_done_ok;
    logic [AES_W-1:0]   w_sel_pt;
    logic [AES_W-1:0]   w_sel_key;

    rr_arb2 u_rr_arb2 (
        .i_req   (req_valid),
        .i_last  (r_last),
        .o_valid (w_any),
        .o_grant (w_gnt)
    );

    assign w_sel_pt  = w_gnt ? req_pt[2*AES_W-1:AES_W]  : req_pt[AES_W-1:0];
    assign w_sel_key = w_gnt ? req_key[2*AES_W-1:AES_W] : req_key[AES_W-1:0];

    // A done level left over from the previous operation is masked during the blank window.
    assign w_done_ok = aes_done && (r_cnt >= BLANK_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_gnt       <= 1'b0;
            r_last      <= 1'b1;
            r_cnt       <= 8'd0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_ct    <= '0;
            r_rsp_err   <= 1'b0;
            r_aes_start <= 1'b0;
            r_aes_pt    <= '0;
            r_aes_key   <= '0;
        end else begin
            r_req_ready <= '0;
            r_aes_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt       <= w_gnt;
                        r_req_ready <= w_gnt ? 2'b10 : 2'b01;
                        r_aes_pt    <= w_sel_pt;
                        r_aes_key   <= w_sel_key;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_aes_start <= 1'b1;
                    r_cnt       <= 8'd0;
                    r_state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt != 8'hff) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                    // Success wins when done qualifies in the same cycle as the timeout.
                    if (w_done_ok) begin
                        r_rsp_ct    <= aes_ct;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= r_gnt ? 2'b10 : 2'b01;
                        r_state     <= ST_RESP;
                    end else if (r_cnt >= TIMEOUT_C) begin
                        r_rsp_ct    <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= r_gnt ? 2'b10 : 2'b01;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready[r_gnt]) begin
                        r_rsp_valid <= '0;
                        r_last      <= r_gnt;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_ct    = r_rsp_ct;
    assign rsp_err   = r_rsp_err;
    assign aes_start = r_aes_start;
    assign aes_pt    = r_aes_pt;
    assign aes_key   = r_aes_key;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_aes_arbiter.sv
// tb/tb_aes_arbiter.sv - directed self-checking bench for aes_arbiter with a behavioural AES core
module tb_aes_arbiter;

    localparam int TO = 31;
    localparam int BL = 2;

    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [255:0] req_pt;
    logic [255:0] req_key;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [127:0] rsp_ct;
    logic         rsp_err;
    logic         aes_start;
    logic [127:0] aes_pt;
    logic [127:0] aes_key;
    logic [127:0] aes_ct   = '0;
    logic         aes_done = 1'b0;
    logic         busy;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  core_lat;
    bit  core_hang;
    int  core_cnt = 0;
    bit  core_run = 1'b0;

    aes_arbiter #(.TIMEOUT(TO), .BLANK(BL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pt    (req_pt),
        .req_key   (req_key),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_ct    (rsp_ct),
        .rsp_err   (rsp_err),
        .aes_start (aes_start),
        .aes_pt    (aes_pt),
        .aes_key   (aes_key),
        .aes_ct    (aes_ct),
        .aes_done  (aes_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(a, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   rk [176];
        logic [7:0]   s  [16];
        logic [7:0]   t  [16];
        logic [7:0]   tw [4];
        logic [7:0]   rc, tmp, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            rk[i] = key[127-8*i -: 8];
            s[i]  = pt[127-8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tw[j] = rk[i-4+j];
            if (i % 16 == 0) begin
                tmp   = tw[0];
                tw[0] = sbox(tw[1]) ^ rc;
                tw[1] = sbox(tw[2]);
                tw[2] = sbox(tw[3]);
                tw[3] = sbox(tmp);
                rc    = xt(rc);
            end
            for (int j = 0; j < 4; j++) rk[i+j] = rk[i-16+j] ^ tw[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox(s[i]);
            for (int rw = 0; rw < 4; rw++)
                for (int c = 0; c < 4; c++) t[rw+4*c] = s[rw+4*((c+rw)%4)];
            for (int i = 0; i < 16; i++) s[i] = t[i];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[16*r+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Core model: done drops on start and rises core_lat cycles after the start cycle.
    always @(posedge clk) begin
        if (aes_start) begin
            core_cnt <= 1;
            core_run <= 1'b1;
            aes_done <= 1'b0;
        end else if (core_run) begin
            if (!core_hang && core_cnt == core_lat - 1) begin
                aes_done <= 1'b1;
                aes_ct   <= aes128(aes_pt, aes_key);
                core_run <= 1'b0;
            end
            core_cnt <= core_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        check("wait_req_ready", 256'(req_ready != 2'b00), 256'(1));
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (rsp_valid == 2'b00 && n < 60) begin
            tick();
            n++;
        end
        check("wait_rsp_valid", 256'(rsp_valid != 2'b00), 256'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] oh;
        bit         bad;
        rst_n = 1'b0; req_valid = 2'b00; req_pt = '0; req_key = '0; rsp_ready = 2'b00;
        core_lat = 3; core_hang = 1'b0;
        tick();
        tick();
        check("rst_req_ready", 256'(req_ready), 256'(2'b00));
        check("rst_rsp", 256'({rsp_valid, rsp_err}), 256'(3'b000));
        check("rst_rsp_ct", 256'(rsp_ct), 256'(0));
        check("rst_start_busy", 256'({aes_start, busy}), 256'(2'b00));
        check("rst_aes_pt_key", {aes_pt, aes_key}, 256'(0));
        rst_n = 1'b1;
        tick();

        // single request, requester 0
        req_pt = {PT_B, PT_A}; req_key = {KEY_B, KEY_A}; req_valid = 2'b01;
        tick();
        check("single_req_ready", 256'({req_ready, busy}), 256'(3'b011));
        check("single_capture", {aes_pt, aes_key}, {PT_A, KEY_A});
        req_valid = 2'b00;
        tick();
        check("single_start", 256'({req_ready, aes_start}), 256'(3'b001));
        tick(); tick(); tick();
        check("single_early", 256'(rsp_valid), 256'(2'b00));
        tick();
        check("single_rsp", 256'({rsp_valid, rsp_err}), 256'(3'b010));
        check("single_ct", 256'(rsp_ct), 256'(CT_A));
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        check("single_idle", 256'({rsp_valid, busy}), 256'(3'b000));

        // contention from reset: grants 0,1,0,1
        do_reset();
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            oh = (k % 2 == 1) ? 2'b10 : 2'b01;
            wait_ready();
            check("cont_grant", 256'(req_ready), 256'(oh));
            tick();
            check("cont_pulse", 256'({req_ready, aes_start}), 256'(3'b001));
            wait_rsp();
            check("cont_rsp_valid", 256'(rsp_valid), 256'(oh));
            check("cont_ct", 256'(rsp_ct), 256'((k % 2 == 1) ? CT_B : CT_A));
            rsp_ready = oh;
            tick();
            rsp_ready = 2'b00;
        end
        req_valid = 2'b00;

        // stale done masked, new done 12 cycles after start
        core_lat = 12;
        req_valid = 2'b01;
        wait_ready();
        req_valid = 2'b00;
        tick();
        check("stale_start", 256'({aes_start, aes_done}), 256'(2'b11));
        bad = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (rsp_valid != 2'b00) bad = 1'b1;
        end
        check("stale_masked", 256'(bad), 256'(0));
        tick();
        check("stale_rsp", 256'({rsp_valid, rsp_err}), 256'(3'b010));
        check("stale_ct", 256'(rsp_ct), 256'(CT_A));

        // backpressure with requester 1 waiting
        req_valid = 2'b10;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_hold", 256'({rsp_valid, rsp_ct, aes_start, req_ready}),
                  256'({2'b01, CT_A, 1'b0, 2'b00}));
        end
        core_lat = 3;
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        check("bp_release", 256'(rsp_valid), 256'(2'b00));
        tick();
        check("bp_next_grant", 256'(req_ready), 256'(2'b10));
        req_valid = 2'b00;
        tick();
        check("bp_next_start", 256'(aes_start), 256'(1));
        wait_rsp();
        check("bp_next_ct", 256'({rsp_valid, rsp_ct}), 256'({2'b10, CT_B}));
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;

        // timeout
        core_hang = 1'b1;
        req_valid = 2'b10;
        wait_ready();
        req_valid = 2'b00;
        tick();
        check("to_start", 256'(aes_start), 256'(1));
        bad = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            tick();
            if (rsp_valid != 2'b00) bad = 1'b1;
        end
        check("to_not_early", 256'(bad), 256'(0));
        tick();
        check("to_rsp", 256'({rsp_valid, rsp_err}), 256'(3'b101));
        check("to_ct_zero", 256'(rsp_ct), 256'(0));
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        check("to_wrong_ready", 256'(rsp_valid), 256'(2'b10));
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;
        check("to_idle", 256'({rsp_valid, busy}), 256'(3'b000));
        core_hang = 1'b0;

        // reset mid-WAIT
        req_valid = 2'b01;
        wait_ready();
        req_valid = 2'b00;
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rstw_outputs", 256'({req_ready, rsp_valid, rsp_err, aes_start, busy, rsp_ct}), 256'(0));
        check("rstw_aes_pt_key", {aes_pt, aes_key}, 256'(0));
        tick();
        rst_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rsp_valid != 2'b00 || busy) bad = 1'b1;
        end
        check("rstw_no_rsp", 256'(bad), 256'(0));
        req_valid = 2'b01;
        wait_ready();
        check("rstw_next_grant", 256'(req_ready), 256'(2'b01));
        req_valid = 2'b00;
        wait_rsp();
        check("rstw_next_rsp", 256'({rsp_valid, rsp_err, rsp_ct}), 256'({2'b01, 1'b0, CT_A}));
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
